// File: rtl/keccak_core_arbiter.sv
// rtl/keccak_core_arbiter.sv - shares one SHA3-512 core between two message requesters
//
// Purpose:
//   Grants the core to one requester per message (round robin on ties),
//   forwards the owner's word stream to the padder, captures the finished
//   hash, and pulses the core reset between messages because the padder's
//   is_last state is sticky.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   in0/in1              requester message words
//   in_ready0/in_ready1  word valid; first assertion requests ownership
//   is_last0/is_last1    word is the final one of the message
//   byte_num0/byte_num1  valid bytes in the final word
//   ack0/ack1            word consumed this cycle
//   hash_valid0/1        hash_out holds this requester's result
//   hash_ack0/1          requester has taken the result
//   hash_out             captured hash (shared)
//   busy                 arbiter is not idle
//   owner                current or most recent owner
//   core_*               padder / permutation interface

module keccak_core_arbiter #(
   parameter int HASH_W       = 512,
   parameter int CLEAR_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       in0,
   input  logic [31:0]       in1,
   input  logic              in_ready0,
   input  logic              in_ready1,
   input  logic              is_last0,
   input  logic              is_last1,
   input  logic [1:0]        byte_num0,
   input  logic [1:0]        byte_num1,
   output logic              ack0,
   output logic              ack1,
   output logic              hash_valid0,
   output logic              hash_valid1,
   input  logic              hash_ack0,
   input  logic              hash_ack1,
   output logic [HASH_W-1:0] hash_out,
   output logic              busy,
   output logic              owner,
   output logic              core_reset,
   output logic [31:0]       core_in,
   output logic              core_in_ready,
   output logic              core_is_last,
   output logic [1:0]        core_byte_num,
   input  logic              core_buffer_full,
   input  logic [HASH_W-1:0] core_out,
   input  logic              core_out_ready
);

   // A one-cycle clear still needs a 1-bit counter.
   localparam int               CNT_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT_HASH,
      S_DELIVER,
      S_CLEAR
   } state_t;

   state_t              r_state;
   logic                r_owner;
   logic                r_last_owner;
   logic                r_hash_valid0;
   logic                r_hash_valid1;
   logic [HASH_W-1:0]   r_hash_out;
   logic [CNT_W-1:0]    r_clr_cnt;

   logic                w_is_stream;
   logic [31:0]         w_own_in;
   logic                w_own_ready;
   logic                w_own_last;
   logic [1:0]          w_own_byte_num;
   logic                w_own_hash_ack;
   logic                w_ack;

   // Owner-side view of the two requesters.
   assign w_own_in       = r_owner ? in1       : in0;
   assign w_own_ready    = r_owner ? in_ready1 : in_ready0;
   assign w_own_last     = r_owner ? is_last1  : is_last0;
   assign w_own_byte_num = r_owner ? byte_num1 : byte_num0;
   assign w_own_hash_ack = r_owner ? hash_ack1 : hash_ack0;

   // Gating with reset keeps a stale STREAM state from acking a word that
   // the reset is about to discard.
   assign w_is_stream = (r_state == S_STREAM) & ~reset;

   // The padder's word handshake: a word moves only when it is offered
   // and the padder has room.
   assign w_ack = w_is_stream & w_own_ready & ~core_buffer_full;

   assign ack0 = w_ack & ~r_owner;
   assign ack1 = w_ack &  r_owner;

   assign core_in       = w_is_stream ? w_own_in : 32'h0;
   assign core_in_ready = w_is_stream & w_own_ready;
   assign core_is_last  = w_is_stream & w_own_last & w_own_ready;
   assign core_byte_num = w_is_stream ? w_own_byte_num : 2'b00;

   // Combinational so the core is also held in reset while we are.
   assign core_reset = reset | (r_state == S_CLEAR);

   assign hash_valid0 = r_hash_valid0;
   assign hash_valid1 = r_hash_valid1;
   assign hash_out    = r_hash_out;
   assign owner       = r_owner;
   assign busy        = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_owner       <= 1'b0;
         r_last_owner  <= 1'b1;
         r_hash_valid0 <= 1'b0;
         r_hash_valid1 <= 1'b0;
         r_hash_out    <= '0;
         r_clr_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_ready0 | in_ready1) begin
                  // On a tie the requester that did not go last wins.
                  if (in_ready0 & in_ready1) begin
                     r_owner <= ~r_last_owner;
                  end else begin
                     r_owner <= in_ready1;
                  end
                  r_state <= S_STREAM;
               end
            end

            S_STREAM: begin
               if (w_ack & w_own_last) begin
                  r_state <= S_WAIT_HASH;
               end
            end

            S_WAIT_HASH: begin
               if (core_out_ready) begin
                  r_hash_out <= core_out;
                  if (r_owner) begin
                     r_hash_valid1 <= 1'b1;
                  end else begin
                     r_hash_valid0 <= 1'b1;
                  end
                  r_state <= S_DELIVER;
               end
            end

            S_DELIVER: begin
               // Only the owner's acknowledge ends delivery.
               if (w_own_hash_ack) begin
                  r_hash_valid0 <= 1'b0;
                  r_hash_valid1 <= 1'b0;
                  r_last_owner  <= r_owner;
                  r_clr_cnt     <= '0;
                  r_state       <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               if (r_clr_cnt == CNT_LAST) begin
                  r_clr_cnt <= '0;
                  r_state   <= S_IDLE;
               end else begin
                  r_clr_cnt <= r_clr_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_core_arbiter.sv
// tb/tb_keccak_core_arbiter.sv - self-checking bench for keccak_core_arbiter

`timescale 1ns/1ps

module tb_keccak_core_arbiter;

   localparam int          HASH_W       = 512;
   localparam int          CLEAR_CYCLES = 2;
   localparam int          GUARD        = 3000;
   localparam int          FULL_CYC     = 4;
   localparam logic [63:0] ACC_INIT     = 64'h0123456789ABCDEF;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [31:0]       in_w [2];
   logic              rdy  [2];
   logic              last [2];
   logic [1:0]        bnum [2];
   logic              hack [2];

   logic              ack0, ack1, hash_valid0, hash_valid1, busy, owner;
   logic [HASH_W-1:0] hash_out;
   logic              core_reset, core_in_ready, core_is_last;
   logic [31:0]       core_in;
   logic [1:0]        core_byte_num;
   logic [HASH_W-1:0] core_out;

   // Stand-in core: order-sensitive digest of the words it really receives.
   logic [63:0]       m_acc;
   int                m_cnt, m_full_cnt, m_lat;
   logic              m_full, m_done, m_ready;
   int                lat_r [2];

   int                n_vec = 0;
   int                n_err = 0;
   logic [HASH_W-1:0] sb0 [$];
   logic [HASH_W-1:0] sb1 [$];
   int                exp_grant [$];

   logic              p_hv0 = 1'b0, p_hv1 = 1'b0, p_busy = 1'b0;
   int                cr_run = 0;

   typedef struct {
      int          req;
      int          nw;
      logic [31:0] seed;
      logic [31:0] step;
      logic [1:0]  bn;
      int          lat;
      int          dly;
      int          exp_owner;
   } vec_t;

   vec_t tbl [4];

   always #5 clk = ~clk;

   keccak_core_arbiter #(.HASH_W(HASH_W), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
      .clk              (clk),
      .reset            (reset),
      .in0              (in_w[0]),
      .in1              (in_w[1]),
      .in_ready0        (rdy[0]),
      .in_ready1        (rdy[1]),
      .is_last0         (last[0]),
      .is_last1         (last[1]),
      .byte_num0        (bnum[0]),
      .byte_num1        (bnum[1]),
      .ack0             (ack0),
      .ack1             (ack1),
      .hash_valid0      (hash_valid0),
      .hash_valid1      (hash_valid1),
      .hash_ack0        (hack[0]),
      .hash_ack1        (hack[1]),
      .hash_out         (hash_out),
      .busy             (busy),
      .owner            (owner),
      .core_reset       (core_reset),
      .core_in          (core_in),
      .core_in_ready    (core_in_ready),
      .core_is_last     (core_is_last),
      .core_byte_num    (core_byte_num),
      .core_buffer_full (m_full),
      .core_out         (core_out),
      .core_out_ready   (m_ready)
   );

   function automatic logic [63:0] mix(input logic [63:0] a, input logic [31:0] w);
      return ({a[58:0], a[63:59]} + {w, ~w}) ^ 64'h9E3779B97F4A7C15;
   endfunction

   function automatic logic [HASH_W-1:0] exp_hash(input int nw, input logic [31:0] seed,
                                                  input logic [31:0] step, input logic [1:0] bn);
      logic [63:0] a;
      a = ACC_INIT;
      for (int i = 0; i < nw; i++) a = mix(a, seed + step * 32'(i));
      a = mix(a, 32'h100 | {30'h0, bn});
      return {8{a}};
   endfunction

   assign core_out = m_ready ? {8{m_acc}} : {16{32'hDEADBEEF}};

   always @(posedge clk) begin
      if (core_reset) begin
         m_acc <= ACC_INIT; m_cnt <= 0; m_full <= 1'b0; m_full_cnt <= 0;
         m_done <= 1'b0; m_lat <= 0; m_ready <= 1'b0;
      end else begin
         if (m_full) begin
            m_full_cnt <= m_full_cnt - 1;
            if (m_full_cnt == 1) m_full <= 1'b0;
         end else if (core_in_ready && !m_done) begin
            if (core_is_last) begin
               m_acc  <= mix(mix(m_acc, core_in), 32'h100 | {30'h0, core_byte_num});
               m_done <= 1'b1;
               if (lat_r[owner] == 0) m_ready <= 1'b1;
               else m_lat <= lat_r[owner];
            end else begin
               m_acc <= mix(m_acc, core_in);
               m_cnt <= m_cnt + 1;
               if (m_cnt % 18 == 17) begin
                  m_full     <= 1'b1;
                  m_full_cnt <= FULL_CYC;
               end
            end
         end
         if (m_lat > 0) begin
            m_lat <= m_lat - 1;
            if (m_lat == 1) m_ready <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_h(input string name, input logic [HASH_W-1:0] act, input logic [HASH_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic hv_of(input int r);
      return (r == 1) ? hash_valid1 : hash_valid0;
   endfunction

   // Scoreboard side: pops expected hashes and grants as the DUT produces them.
   always @(negedge clk) begin
      if (!reset) begin
         if (hash_valid0 && !p_hv0) begin
            if (sb0.size() == 0) chk("hv0_unexpected", 32'(hash_valid0), 0);
            else chk_h("hash0", hash_out, sb0.pop_front());
         end
         if (hash_valid1 && !p_hv1) begin
            if (sb1.size() == 0) chk("hv1_unexpected", 32'(hash_valid1), 0);
            else chk_h("hash1", hash_out, sb1.pop_front());
         end
         if (hash_valid0 || hash_valid1) chk("hv_exclusive", 32'(hash_valid0 & hash_valid1), 0);
         if (ack0 || ack1) chk("ack_nonowner", 32'(owner ? ack0 : ack1), 0);
         if (m_full) chk("ack_while_full", 32'(ack0 | ack1), 0);
         if (busy && !p_busy) begin
            if (exp_grant.size() == 0) chk("grant_unexpected", 32'(busy), 0);
            else chk("grant_owner", 32'(owner), 32'(exp_grant.pop_front()));
         end
         if (core_reset) cr_run <= cr_run + 1;
         else if (cr_run > 0) begin
            chk("clear_len", 32'(cr_run), 32'(CLEAR_CYCLES));
            cr_run <= 0;
         end
      end else begin
         cr_run <= 0;
      end
      p_hv0  <= hash_valid0;
      p_hv1  <= hash_valid1;
      p_busy <= busy;
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      for (int r = 0; r < 2; r++) begin
         rdy[r] = 1'b0; last[r] = 1'b0; bnum[r] = 2'b00; hack[r] = 1'b0;
      end
      @(negedge clk);
      chk("core_reset_in_reset", 32'(core_reset), 1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ack0", 32'(ack0), 0);
      chk("rst_ack1", 32'(ack1), 0);
      chk("rst_hv0", 32'(hash_valid0), 0);
      chk("rst_hv1", 32'(hash_valid1), 0);
      chk_h("rst_hash_out", hash_out, '0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_core_reset", 32'(core_reset), 0);
      chk("rst_core_in_ready", 32'(core_in_ready), 0);
   endtask

   task automatic push_word(input int r, input logic [31:0] w, input logic l,
                            input logic [1:0] bn, output logic ok);
      int   g;
      logic got;
      g = 0; got = 1'b0;
      in_w[r] = w; rdy[r] = 1'b1; last[r] = l; bnum[r] = bn;
      while (!got && g < GUARD) begin
         @(negedge clk);
         got = (r == 1) ? ack1 : ack0;
         @(posedge clk); #1;
         g++;
      end
      chk("word_acked", 32'(got), 1);
      ok = got;
   endtask

   task automatic send_msg(input int r, input int nw, input logic [31:0] seed, input logic [31:0] step,
                           input logic [1:0] bn, input int lat, input int dly);
      logic ok;
      int   g;
      lat_r[r] = lat;
      if (r == 0) sb0.push_back(exp_hash(nw, seed, step, bn));
      else        sb1.push_back(exp_hash(nw, seed, step, bn));
      for (int i = 0; i < nw; i++) begin
         push_word(r, seed + step * 32'(i), (i == nw - 1), (i == nw - 1) ? bn : 2'b00, ok);
         if (!ok) begin
            rdy[r] = 1'b0; last[r] = 1'b0;
            return;
         end
      end
      rdy[r] = 1'b0; last[r] = 1'b0; bnum[r] = 2'b00;
      g = 0;
      while (!hv_of(r) && g < GUARD) begin
         @(posedge clk); #1;
         g++;
      end
      chk("hash_valid_seen", 32'(hv_of(r)), 1);
      if (!hv_of(r)) return;
      for (int k = 0; k < dly; k++) begin
         @(posedge clk); #1;
      end
      hack[r] = 1'b1;
      @(posedge clk); #1;
      hack[r] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic ok;
      int   g;

      tbl[0] = '{0,  3, 32'h11111111, 32'h01020304, 2'd2, 3, 0, 0};
      tbl[1] = '{1, 20, 32'hA0000000, 32'h00000007, 2'd1, 5, 1, 1};
      tbl[2] = '{0,  1, 32'h61626300, 32'h00000000, 2'd3, 0, 2, 0};
      tbl[3] = '{1,  2, 32'hCAFEF00D, 32'h10000001, 2'd0, 8, 0, 1};

      for (int r = 0; r < 2; r++) begin
         in_w[r] = '0; rdy[r] = 1'b0; last[r] = 1'b0; bnum[r] = 2'b00; hack[r] = 1'b0; lat_r[r] = 4;
      end

      // Reset state.
      do_reset();

      // Single "abc" message with cycle-level checks.
      lat_r[0] = 4;
      sb0.push_back(exp_hash(1, 32'h61626300, 32'h0, 2'd3));
      exp_grant.push_back(0);
      @(posedge clk); #1;
      in_w[0] = 32'h61626300; rdy[0] = 1'b1; last[0] = 1'b1; bnum[0] = 2'd3;
      @(negedge clk);
      chk("ack0_idle_cycle", 32'(ack0), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ack0_stream", 32'(ack0), 1);
      chk("core_in", core_in, 32'h61626300);
      chk("core_is_last", 32'(core_is_last), 1);
      chk("core_byte_num", 32'(core_byte_num), 3);
      @(posedge clk); #1;
      rdy[0] = 1'b0; last[0] = 1'b0; bnum[0] = 2'b00;
      g = 0;
      while (!hash_valid0 && g < GUARD) begin
         @(posedge clk); #1;
         g++;
      end
      chk("abc_hv0", 32'(hash_valid0), 1);
      hack[0] = 1'b1;
      @(posedge clk); #1;
      hack[0] = 1'b0;
      @(negedge clk);
      chk("clear_c0", 32'(core_reset), 1);
      @(negedge clk);
      chk("clear_c1", 32'(core_reset), 1);
      @(negedge clk);
      chk("clear_done_core_reset", 32'(core_reset), 0);
      chk("clear_done_busy", 32'(busy), 0);

      // Tie straight after reset: requester 0 first.
      do_reset();
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      fork
         send_msg(0, 2, 32'h01234567, 32'h00000100, 2'd1, 2, 0);
         send_msg(1, 3, 32'h89ABCDEF, 32'h00010001, 2'd2, 3, 0);
      join

      // Round robin from the table: both requesters continuously busy.
      for (int k = 0; k < 4; k++) exp_grant.push_back(tbl[k].exp_owner);
      fork
         begin
            for (int k = 0; k < 4; k++)
               if (tbl[k].req == 0)
                  send_msg(0, tbl[k].nw, tbl[k].seed, tbl[k].step, tbl[k].bn, tbl[k].lat, tbl[k].dly);
         end
         begin
            for (int k = 0; k < 4; k++)
               if (tbl[k].req == 1)
                  send_msg(1, tbl[k].nw, tbl[k].seed, tbl[k].step, tbl[k].bn, tbl[k].lat, tbl[k].dly);
         end
      join

      // Backpressure: 18 zero words fill the buffer, then a 0-byte final word.
      exp_grant.push_back(0);
      send_msg(0, 19, 32'h0, 32'h0, 2'd0, 6, 0);

      // Delayed hash_ack with the other requester knocking.
      exp_grant.push_back(0);
      exp_grant.push_back(1);
      fork
         send_msg(0, 1, 32'h0BADC0DE, 32'h0, 2'd2, 3, 10);
         begin
            repeat (3) @(posedge clk);
            #1;
            send_msg(1, 2, 32'h13572468, 32'h11111111, 2'd1, 2, 0);
         end
         begin : watch
            logic [HASH_W-1:0] h;
            int                gw;
            h  = exp_hash(1, 32'h0BADC0DE, 32'h0, 2'd2);
            gw = 0;
            @(negedge clk);
            while (!hash_valid0 && gw < GUARD) begin
               @(negedge clk);
               gw++;
            end
            chk("dly_hv0_seen", 32'(hash_valid0), 1);
            for (int i = 0; i < 10; i++) begin
               chk("dly_hv0_hold", 32'(hash_valid0), 1);
               chk_h("dly_hash_hold", hash_out, h);
               chk("dly_owner", 32'(owner), 0);
               chk("dly_no_ack1", 32'(ack1), 0);
               hack[1] = (i == 2 || i == 5);
               @(negedge clk);
            end
            hack[1] = 1'b0;
         end
      join

      // Reset part way through a message from requester 1, then restart it.
      exp_grant.push_back(1);
      lat_r[1] = 4;
      for (int i = 0; i < 5; i++) push_word(1, 32'h50000000 + 32'(i), 1'b0, 2'b00, ok);
      rdy[1] = 1'b0;
      do_reset();
      exp_grant.push_back(1);
      send_msg(1, 8, 32'h50000000, 32'h1, 2'd3, 4, 1);

      repeat (4) @(negedge clk);
      chk("sb0_drained", 32'(sb0.size()), 0);
      chk("sb1_drained", 32'(sb1.size()), 0);
      chk("grants_drained", 32'(exp_grant.size()), 0);
      chk("end_idle", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/keccak_core_arbiter.md
Name: keccak_core_arbiter

Overview:
- Shares one SHA3-512 core (padder + f_permutation + hash output) between two message requesters.
- Arbitration is message-granular: a requester keeps ownership from its first word until it has acknowledged its hash.
- The block also sequences the core. It forwards the owner's word stream using the padder's word-level handshake, captures the hash, and pulses the core reset between messages. The padder's is_last state is sticky, so each new message needs this reset.

Parameters:
- HASH_W, 512, width of the core hash output and captured result.
- CLEAR_CYCLES, 2, number of cycles core_reset is held high between messages (minimum 1).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in0 / in1  input  32  requester message word.
- in_ready0 / in_ready1  input  1  word valid; first assertion also requests ownership.
- is_last0 / is_last1  input  1  current word is final; must be 0 when in_ready is 0.
- byte_num0 / byte_num1  input  2  valid bytes in the final word (0 means 0 bytes); meaningful only when is_last is 1.
- ack0 / ack1  output  1  word consumed this cycle; requester advances only on ack.
- hash_valid0 / hash_valid1  output  1  hash_out holds this requester's result.
- hash_ack0 / hash_ack1  input  1  requester has taken the result.
- hash_out  output  HASH_W  captured hash, shared by both requesters.
- busy  output  1  state is not IDLE.
- owner  output  1  index of the current or most recent owner.
- core_reset  output  1  reset to the core.
- core_in  output  32  word to the padder.
- core_in_ready  output  1  padder in_ready.
- core_is_last  output  1  padder is_last.
- core_byte_num  output  2  padder byte_num.
- core_buffer_full  input  1  padder buffer_full.
- core_out  input  HASH_W  core hash output.
- core_out_ready  input  1  hash complete; level signal, stays high until core reset.

Behaviour:
- States: IDLE, STREAM, WAIT_HASH, DELIVER, CLEAR.
- Reset values:
  - state IDLE; owner 0; last_owner 1, so requester 0 wins the first tie.
  - ack 0; hash_valid 0; hash_out 0; busy 0.
  - Clear counter 0.
  - core_reset = reset OR (state==CLEAR), combinational, so the core is held in reset during reset.
- Reset mid-operation: everything returns to the reset values next cycle. Any partial message is discarded and the requester must restart it.
- IDLE:
  - If exactly one in_ready is high, that requester is granted.
  - If both are high, the requester not equal to last_owner is granted.
  - The grant registers owner and moves to STREAM next cycle, so there is 1 cycle of arbitration latency.
  - No ack is given in IDLE.
- STREAM, core mux:
  - core_in = in[owner]; core_in_ready = in_ready[owner].
  - core_is_last = is_last[owner] & in_ready[owner].
  - core_byte_num = byte_num[owner].
  - These are combinational, with no added latency.
- STREAM, handshake:
  - ack[owner] = in_ready[owner] & ~core_buffer_full (combinational); ack of the non-owner is 0.
  - in_ready[owner] low: no transfer; the block stays in STREAM with no timeout.
  - core_buffer_full high: ack is 0, and the word is held by the requester.
  - ack & is_last[owner] moves the state to WAIT_HASH.
- Core outputs outside STREAM: core_in, core_in_ready, core_is_last and core_byte_num are all 0.
- WAIT_HASH:
  - When core_out_ready is 1: hash_out <= core_out, hash_valid[owner] <= 1, state moves to DELIVER.
  - If core_out_ready is already high on entry, capture happens on the first WAIT_HASH cycle.
- DELIVER:
  - hash_valid[owner] holds high.
  - hash_ack[owner] moves to CLEAR and, on the same edge, clears hash_valid and sets last_owner <= owner.
  - hash_ack is sampled only in DELIVER and only from the owner; the non-owner's hash_ack is ignored.
  - hash_out is retained after DELIVER until the next capture.
- CLEAR:
  - core_reset is high for exactly CLEAR_CYCLES cycles; the counter counts 0..CLEAR_CYCLES-1.
  - The state then moves to IDLE. Requests arriving during CLEAR wait for IDLE.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1,...
- Full message latency from ack of the last word to hash_valid: core latency + 1 cycle.

Test Plan:
- Single message: after reset, req0 sends 0x61626300 with is_last=1, byte_num=3, other requester idle. Required: ack0 after 1 IDLE cycle; hash_valid0 rises with hash_out = SHA3-512("abc"); after hash_ack0, core_reset is high for 2 cycles, then busy=0.
- Tie after reset: in_ready0=in_ready1=1 in the same cycle. Required: owner=0 first, ack1 stays 0 throughout; after req0's hash_ack, owner=1 and req1's hash is correct.
- Round robin: both request continuously for 4 messages. Required: grant order 0,1,0,1; every hash matches its message.
- Backpressure: req0 streams 18 words of 0x00000000 then a final word with byte_num=0. Required: ack0 is 0 while core_buffer_full is 1, no word is lost or duplicated, and the hash equals SHA3-512 of 72 zero bytes.
- Delayed ack: hold hash_ack0 low for 10 cycles. Required: hash_valid0 and hash_out stable for all 10 cycles; in_ready1 gets no ack until CLEAR finishes; hash_ack1 pulses during this time are ignored.
- Reset mid-stream: assert reset after 5 words of req1. Required: next cycle ack=0, hash_valid=0, hash_out=0, state IDLE, core_reset high during reset; a restarted message then produces the correct hash.
